// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction-memory request/response bus between fetch unit and imem
//   imem_req    fetch request, held until imem_rvalid
//   imem_addr   14-bit word address
//   imem_rvalid response strobe, accepted only while a request is open
//   imem_rdata  32-bit instruction word
interface ifetch_unit_if;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  modport master(output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC sequencing and instruction fetch (IDLE -> REQ -> EXEC loop, optional FAULT)
//   clock, reset_n            rising-edge clock, async active-low reset
//   Addr_Result, Zero         branch target and zero flag from execute
//   Read_data_1               rs value, Jr target
//   Branch/nBranch/Jmp/Jal/Jr control decode of the current Instruction
//   cpu_stall                 holds the current instruction in EXEC
//   imem                      ifetch_unit_if master (req/addr/rvalid/rdata)
//   Instruction, PC_plus_4, link_addr, instr_valid, fetch_fault
//   IFETCH_ALIGN_CHECK_EN     when defined, a misaligned Jr target locks the unit in FAULT
module ifetch_unit (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [31:0]          Addr_Result,
  input  logic                 Zero,
  input  logic [31:0]          Read_data_1,
  input  logic                 Branch,
  input  logic                 nBranch,
  input  logic                 Jmp,
  input  logic                 Jal,
  input  logic                 Jr,
  input  logic                 cpu_stall,
  ifetch_unit_if.master        imem,
  output logic [31:0]          Instruction,
  output logic [31:0]          PC_plus_4,
  output logic [31:0]          link_addr,
  output logic                 instr_valid,
  output logic                 fetch_fault
);
  typedef enum logic [1:0] {IDLE, REQ, EXEC, FAULT} state_t;
  state_t state, state_nx;
  logic [31:0] pc, next_pc, jr_tgt;
  logic commit, taken, misalign;
  assign PC_plus_4 = pc + 32'd4;
  assign imem.imem_addr = pc[15:2];
  assign commit = instr_valid & ~cpu_stall;
  assign taken = (Branch & Zero) | (nBranch & ~Zero);
`ifdef IFETCH_ALIGN_CHECK_EN
  assign jr_tgt = Read_data_1;
  assign misalign = Jr & |Read_data_1[1:0];
  assign fetch_fault = state == FAULT;
`else
  assign jr_tgt = Read_data_1 & 32'hFFFF_FFFC;
  assign misalign = 1'b0;
  assign fetch_fault = 1'b0;
`endif
  assign next_pc = Jr ? jr_tgt :
                   (Jmp | Jal) ? {PC_plus_4[31:28], Instruction[25:0], 2'b00} :
                   taken ? Addr_Result : PC_plus_4;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // Outputs decode from the state register only, so nothing depends combinationally on imem_rdata.
  always_comb begin
    state_nx = state;
    imem.imem_req = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE: state_nx = REQ;
      REQ: begin
        imem.imem_req = 1'b1;
        state_nx = imem.imem_rvalid ? EXEC : REQ;
      end
      EXEC: begin
        instr_valid = 1'b1;
        state_nx = ~commit ? EXEC : misalign ? FAULT : REQ;
      end
      default: state_nx = state;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pc <= '0;
      Instruction <= '0;
      link_addr <= '0;
    end else begin
      if (state == REQ && imem.imem_rvalid) Instruction <= imem.imem_rdata;
      if (commit && !misalign) pc <= next_pc;
      if (commit && Jal) link_addr <= PC_plus_4;
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed checks of fetch sequencing, branches, jumps, stall, reset and wrap
module tb_ifetch_unit;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] Addr_Result = '0, Read_data_1 = '0;
  logic Zero = 1'b0, Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jr = 1'b0, cpu_stall = 1'b0;
  logic [31:0] Instruction, PC_plus_4, link_addr;
  logic instr_valid, fetch_fault;
  int checks = 0, errors = 0;
  ifetch_unit_if bus();
  ifetch_unit dut (
    .clock(clock), .reset_n(reset_n), .Addr_Result(Addr_Result), .Zero(Zero),
    .Read_data_1(Read_data_1), .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp),
    .Jal(Jal), .Jr(Jr), .cpu_stall(cpu_stall), .imem(bus), .Instruction(Instruction),
    .PC_plus_4(PC_plus_4), .link_addr(link_addr), .instr_valid(instr_valid),
    .fetch_fault(fetch_fault)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic serve(input logic [31:0] data);
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.imem_req) chk("req_timeout", 32'd0, 32'd1);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = data;
    @(negedge clock);
    bus.imem_rvalid = 1'b0;
  endtask
  task automatic exec(input logic jr, input logic jmp, input logic jal, input logic br,
                      input logic nbr, input logic z, input logic [31:0] ar, input logic [31:0] rd1);
    Jr = jr; Jmp = jmp; Jal = jal; Branch = br; nBranch = nbr; Zero = z;
    Addr_Result = ar; Read_data_1 = rd1;
    @(negedge clock);
    Jr = 0; Jmp = 0; Jal = 0; Branch = 0; nBranch = 0; Zero = 0;
    Addr_Result = '0; Read_data_1 = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", Instruction, 0);
    chk("rst_link", link_addr, 0);
    chk("rst_pc4", PC_plus_4, 32'h4);
    chk("rst_fault", fetch_fault, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("first_req", bus.imem_req, 1);
    chk("first_addr", bus.imem_addr, 0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h2008_0005;
    @(negedge clock);
    bus.imem_rvalid = 1'b0;
    chk("first_valid", instr_valid, 1);
    chk("first_instr", Instruction, 32'h2008_0005);
    chk("first_req_drop", bus.imem_req, 0);
    exec(0, 0, 0, 0, 0, 0, 0, 0);
    chk("seq_addr", bus.imem_addr, 14'h1);
    chk("seq_pc4", PC_plus_4, 32'h8);
    chk("seq_valid", instr_valid, 0);
    serve(32'h0800_0010);
    exec(0, 1, 0, 0, 0, 0, 0, 0);
    chk("jmp40_addr", bus.imem_addr, 14'h10);
    serve(32'h1000_0000);
    exec(0, 0, 0, 1, 0, 1, 32'h100, 0);
    chk("beq_taken", bus.imem_addr, 14'h40);
    serve(32'h0800_0010);
    exec(0, 1, 0, 0, 0, 0, 0, 0);
    serve(32'h1000_0000);
    exec(0, 0, 0, 1, 0, 0, 32'h100, 0);
    chk("beq_not_taken", bus.imem_addr, 14'h11);
    chk("beq_nt_pc4", PC_plus_4, 32'h48);
    serve(32'h1400_0000);
    exec(0, 0, 0, 1, 1, 0, 32'h200, 0);
    chk("both_br_taken", bus.imem_addr, 14'h80);
    serve(32'h0800_0008);
    exec(0, 1, 0, 0, 0, 0, 0, 0);
    chk("jmp20_addr", bus.imem_addr, 14'h8);
    serve(32'h0C00_0080);
    exec(0, 0, 1, 0, 0, 0, 0, 0);
    chk("jal_addr", bus.imem_addr, 14'h80);
    chk("jal_pc4", PC_plus_4, 32'h204);
    chk("jal_link", link_addr, 32'h24);
    serve(32'h03E0_0008);
    exec(1, 0, 0, 0, 0, 0, 0, 32'h24);
    chk("jr_addr", bus.imem_addr, 14'h9);
    chk("jr_link_hold", link_addr, 32'h24);
    serve(32'h03E0_0008);
    exec(1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    chk("top_pc4_wrap", PC_plus_4, 32'h0);
    chk("top_addr", bus.imem_addr, 14'h3FFF);
    serve(32'h0);
    exec(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_addr", bus.imem_addr, 14'h0);
    chk("wrap_pc4", PC_plus_4, 32'h4);
    serve(32'h1111_1111);
    cpu_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
      end
      @(negedge clock);
      bus.imem_rvalid = 1'b0;
      chk("stall_valid", instr_valid, 1);
      chk("stall_req", bus.imem_req, 0);
      chk("stall_pc4", PC_plus_4, 32'h4);
    end
    chk("stall_instr", Instruction, 32'h1111_1111);
    cpu_stall = 1'b0;
    @(negedge clock);
    chk("unstall_addr", bus.imem_addr, 14'h1);
    @(negedge clock);
    chk("unstall_once", PC_plus_4, 32'h8);
    chk("unstall_req", bus.imem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", bus.imem_req, 0);
    chk("arst_pc4", PC_plus_4, 32'h4);
    chk("arst_instr", Instruction, 0);
    chk("arst_link", link_addr, 0);
    chk("arst_valid", instr_valid, 0);
    @(negedge clock);
    reset_n = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    @(negedge clock);
    bus.imem_rvalid = 1'b0;
    chk("late_rvalid_instr", Instruction, 0);
    chk("late_rvalid_req", bus.imem_req, 1);
    chk("late_rvalid_addr", bus.imem_addr, 14'h0);
    serve(32'h2008_0005);
    chk("refetch_instr", Instruction, 32'h2008_0005);
    exec(1, 0, 0, 0, 0, 0, 0, 32'h103);
`ifdef IFETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      chk("fault_flag", fetch_fault, 1);
      chk("fault_req", bus.imem_req, 0);
      chk("fault_valid", instr_valid, 0);
      @(negedge clock);
    end
`else
    chk("jr_align_addr", bus.imem_addr, 14'h40);
    chk("jr_align_pc4", PC_plus_4, 32'h104);
    chk("jr_no_fault", fetch_fault, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: Addr_Result  in  32  branch target from execute stage.
REQ-004 SHALL have ports: Zero  in  1  execute-stage zero flag.
REQ-005 SHALL have ports: Read_data_1  in  32  rs value, Jr target.
REQ-006 SHALL have ports: Branch, nBranch, Jmp, Jal, Jr  in  1 each  control-unit decode of current Instruction.
REQ-007 SHALL have ports: cpu_stall  in  1  hold current instruction (IO wait).
REQ-008 SHALL have ports: imem_req  out  1; imem_addr  out  14  word address; imem_rvalid  in  1; imem_rdata  in  32.
REQ-009 SHALL have ports: Instruction  out  32; PC_plus_4  out  32; link_addr  out  32; instr_valid  out  1; fetch_fault  out  1.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, EXEC, FAULT.
REQ-011 IDLE SHALL move to REQ on the first clock edge after reset release.
REQ-012 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal PC[15:2], held stable until imem_rvalid.
REQ-013 On imem_rvalid in REQ, Instruction SHALL latch imem_rdata and state SHALL become EXEC next cycle; imem_req SHALL drop the same edge.
REQ-014 imem_rvalid outside REQ SHALL be ignored.
REQ-015 instr_valid SHALL be 1 exactly while in EXEC; commit = instr_valid & !cpu_stall.
REQ-016 In EXEC with cpu_stall=1, PC, Instruction and state SHALL hold.
REQ-017 On commit, PC SHALL load next_pc and state SHALL become REQ (min. 2 cycles per instruction with 1-cycle memory).
REQ-018 next_pc priority: Jr -> Read_data_1; else Jmp|Jal -> {PC_plus_4[31:28], Instruction[25:0], 2'b00}; else (Branch&Zero)|(nBranch&!Zero) -> Addr_Result; else PC+4.
REQ-019 PC_plus_4 SHALL be combinational PC+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
REQ-020 imem_addr SHALL wrap naturally: only PC[15:2] used, upper bits ignored.
REQ-021 On commit with Jal=1, link_addr SHALL load PC_plus_4; otherwise link_addr holds.
REQ-022 Branch and nBranch both 1 SHALL be treated as taken iff either condition holds.
REQ-023 Outputs SHALL have no combinational path from imem_rdata.

Reset
REQ-024 reset_n=0 SHALL immediately force: state IDLE, PC 0x00000000, Instruction 0, link_addr 0, imem_req 0, instr_valid 0, fetch_fault 0.
REQ-025 Reset asserted mid-REQ SHALL abandon the request; a late imem_rvalid after release SHALL be ignored per REQ-014.

Configuration
REQ-026 Macro IFETCH_ALIGN_CHECK_EN SHALL gate misaligned-jump checking.
REQ-027 Defined: commit with Jr=1 and Read_data_1[1:0]!=0 SHALL enter FAULT; fetch_fault=1, imem_req=0, instr_valid=0, PC holds; exit only by reset.
REQ-028 Undefined: Jr target SHALL be {Read_data_1[31:2], 2'b00}; FAULT unreachable; fetch_fault tied 0.

Verification
REQ-029 Reset release, memory returns 0x20080005 one cycle after req -> imem_addr=0 in REQ, instr_valid=1 next cycle, then imem_addr=1, PC_plus_4=0x8.
REQ-030 PC=0x40, Branch=1, Zero=1, Addr_Result=0x100 on commit -> next imem_addr=0x40; repeat with Zero=0 -> imem_addr=0x11.
REQ-031 PC=0x20, Jal=1, Instruction[25:0]=0x0000080 -> PC=0x200, link_addr=0x24; then Jr=1, Read_data_1=0x24 -> PC=0x24.
REQ-032 cpu_stall=1 for 5 EXEC cycles -> instr_valid stays 1, no imem_req, PC unchanged; release -> single PC advance.
REQ-033 Reset pulsed while imem_req=1, rvalid arrives 1 cycle after release -> ignored; first fetch is address 0.
REQ-034 Jr=1, Read_data_1=0x103: with IFETCH_ALIGN_CHECK_EN -> fetch_fault=1, no further imem_req; without -> PC=0x100.
